// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package rv_fetch_pkg;

  localparam int unsigned FETCH_AW    = 16;
  localparam int unsigned FETCH_DW    = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [FETCH_AW-1:0] RESET_PC_DEFAULT = '0;

  // One prefetch-queue slot: the fetched word tagged with its byte address.
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; storage is read by pointer so the
// head is always a registered value.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  fetch_entry_t    entry_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CW-1:0]   count_o,
  output fetch_entry_t    head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so head outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures instr_mem words into a
// prefetch queue and hands {pc, instr} to decode with a valid/ready handshake.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = FETCH_AW,
  parameter int unsigned              DATA_WIDTH    = FETCH_DW,
  parameter int unsigned              DEPTH         = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     if_valid_o,
  input  logic                     id_ready_i,
  output logic [DATA_WIDTH-1:0]    if_instr_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_plus4_o,
  output logic                     misaligned_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     misaligned_q, misaligned_d;

  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          fetch_fire;

  // Handshake: the head is never offered while a redirect is being taken.
  assign if_valid_o = (fifo_count != '0) && !redirect_i;
  assign pop        = if_valid_o && id_ready_i;
  assign fetch_fire = !redirect_i && (!fifo_full || pop);

  assign wr_entry.pc    = FETCH_AW'(pc_q);
  assign wr_entry.instr = FETCH_DW'(instr_i);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fetch_fire),
    .pop_i   (pop),
    .clear_i (redirect_i),
    .entry_i (wr_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // PC and misalign-flag next-state; redirect overrides sequential fetch.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    if (redirect_i) begin
      pc_d         = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
      misaligned_d = |redirect_pc_i[1:0];
    end else if (fetch_fire) begin
      pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  // PC and misalign-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = misaligned_q;
  assign if_instr_o   = DATA_WIDTH'(head.instr);
  assign if_pc_o      = ADDRESS_WIDTH'(head.pc);
  // Link address reads as zero while nothing is queued (covers the reset value).
  assign if_pc_plus4_o = fifo_empty ? '0 : if_pc_o + ADDRESS_WIDTH'(INSTR_BYTES);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of instr_mem. Owns the program counter and drives the byte address into instr_mem. Captures the combinationally returned 32-bit word together with its PC into a small prefetch queue. Presents {pc, instr} to decode via a valid/ready handshake, and accepts redirects (branch/jump/flush) from later stages.

Parameters:
ADDRESS_WIDTH, 16, PC / instruction byte-address width; matches instr_mem.
DATA_WIDTH, 32, instruction word width.
DEPTH, 2, prefetch queue entries; power of two, at least 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
pc_o  output  ADDRESS_WIDTH  fetch address to instr_mem (equals pc_q).
instr_i  input  DATA_WIDTH  word returned by instr_mem for pc_o, same cycle.
redirect_i  input  1  load new PC and discard all queued instructions.
redirect_pc_i  input  ADDRESS_WIDTH  redirect target byte address.
if_valid_o  output  1  queue head is valid for decode.
id_ready_i  input  1  decode accepts head this cycle.
if_instr_o  output  DATA_WIDTH  head instruction.
if_pc_o  output  ADDRESS_WIDTH  head PC.
if_pc_plus4_o  output  ADDRESS_WIDTH  head PC + 4, for link writeback.
misaligned_o  output  1  one-cycle pulse: last accepted redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc_q = RESET_PC; queue count = 0; read/write pointers = 0; misaligned_o = 0.
  - if_valid_o = 0; if_instr_o, if_pc_o, if_pc_plus4_o = 0.
  - Reset mid-operation discards all queued entries immediately.
- pop = if_valid_o && id_ready_i.
- if_valid_o = (count != 0) && !redirect_i. The head is never offered in a redirect cycle.
- fetch_fire = !redirect_i && (count < DEPTH || pop).
  - Full queue with simultaneous pop still fetches.
- On fetch_fire at the clock edge:
  - Write {pc_q, instr_i} at the write pointer.
  - pc_q <= pc_q + 4, truncated to ADDRESS_WIDTH (wraps 0xFFFC -> 0x0000).
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Pointers wrap modulo DEPTH.
- Redirect has priority over everything:
  - Count and pointers are cleared; no push and no pop that cycle.
  - pc_q <= {redirect_pc_i[AW-1:2], 2'b00}.
  - misaligned_o <= |redirect_pc_i[1:0] (registered; visible the next cycle for one cycle).
  - The first instruction from the new target is valid 2 cycles after the redirect edge: fetched in the cycle after, visible the cycle after that.
- Redirect held high for N cycles: pc_q is reloaded each cycle and the queue stays empty.
- Latency: instruction fetched in cycle k appears at the queue head at the earliest in cycle k+1. There is no combinational instr_i -> if_instr_o path.
- Empty queue: head outputs hold their last values (don't-care), but if_valid_o = 0.
- Steady state with id_ready_i = 1: one instruction per cycle, no bubbles.
- id_ready_i low: the queue fills to DEPTH, then pc_q freezes until a pop.
- Outputs change only on clk or rst_n, except if_valid_o's redirect_i gating.
- Head outputs come from queue storage selected by the read pointer. if_pc_plus4_o = if_pc_o + 4, truncated.

Decomposition:
- Shared package (rv_fetch_pkg):
  - fetch_entry_t packed struct {pc[ADDRESS_WIDTH], instr[DATA_WIDTH]}.
  - Constants: RESET_PC default, INSTR_BYTES = 4.
- One natural sub-module, fetch_fifo:
  - Parameterised DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count, head.
  - Async active-low reset.
- fetch_unit holds the PC register, fetch_fire / redirect control, and misalign flag.

Test Plan:
- Reset then free-run, id_ready_i = 1, instr_mem preloaded with 0x00000013 + (4*i):
  - pc_o sequence 0, 4, 8, ...
  - if_valid_o first high in cycle 1 after reset with if_pc_o = 0, if_instr_o = 0x00000013.
  - One instruction per cycle thereafter.
- Backpressure, id_ready_i = 0 for 5 cycles from PC 0:
  - Count reaches 2; pc_o freezes at 0x0008.
  - On release, heads 0x0000, 0x0004, 0x0008 in order with no loss or duplication.
- Redirect_i = 1 with redirect_pc_i = 0x0100 while the queue holds 2 entries:
  - if_valid_o = 0 that cycle; queue emptied.
  - pc_o = 0x0100 next cycle; if_pc_o = 0x0100 valid one cycle later; misaligned_o stays 0.
- Redirect to 0x0102:
  - pc_o = 0x0100; misaligned_o pulses high for exactly one cycle.
- Wrap: redirect to 0xFFFC, id_ready_i = 1:
  - Heads 0xFFFC then 0x0000; if_pc_plus4_o = 0x0000 for the 0xFFFC entry.
- Full queue with simultaneous pop, and async reset asserted mid-stream while full:
  - Full + pop: fetch continues and count stays 2.
  - Reset: if_valid_o drops to 0 immediately; pc_o = RESET_PC before the next clock edge.
